// File: rtl/mac_sign_restore_acc.sv
// Post-multiplier sign restore and accumulate: per-lane negation over a segmented carry chain, lane extension, MUL/MAC stage.
// Optional sticky per-lane overflow flags are built only when MAC_SIGN_RESTORE_OVF_EN is defined.
module mac_sign_restore_acc #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
  parameter int MAC_ACC_WIDTH  = 2*MAC_MULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [MAC_CONF_WIDTH-1:0]   cfg,
  input  logic                        in_valid,
  input  logic                        acc_clr,
  input  logic [4*MAC_MULT_WIDTH-1:0] prod_in,
  input  logic                        C0_neg,
  input  logic                        C1_neg,
  input  logic                        C2_neg,
  input  logic                        C3_neg,
  output logic [4*MAC_ACC_WIDTH-1:0]  acc_out,
  output logic                        out_valid,
  output logic [3:0]                  ovf
);

  localparam int SEG_W = MAC_MULT_WIDTH;
  localparam int ACC_W = MAC_ACC_WIDTH;
  localparam int P_W   = 4*SEG_W;
  localparam int A_W   = 4*ACC_W;

  typedef enum logic [1:0] {
    LM_SINGLE = 2'd0,
    LM_DUAL   = 2'd1,
    LM_QUAD   = 2'd2
  } lane_mode_t;

  function automatic lane_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return LM_DUAL;
      2'b10:   return LM_QUAD;
      default: return LM_SINGLE;
    endcase
  endfunction

  // Lanes whose top bit sits at (k+1)*ACC_W-1 report on ovf[k].
  function automatic logic [3:0] lane_top_mask(input lane_mode_t m);
    case (m)
      LM_DUAL: return 4'b1010;
      LM_QUAD: return 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  // ---------------- stage 0: negate and extend ----------------
  lane_mode_t             mode_p0;
  logic [3:0]             seg_neg_p0;
  logic [3:0]             seg_start_p0;
  logic [P_W-1:0]         neg_p0;
  logic [A_W-1:0]         ext_p0;
  logic                   sgn_p0;

  assign mode_p0 = decode_mode(cfg[1:0]);
  assign sgn_p0  = cfg[3];

  always_comb begin
    seg_start_p0 = 4'b1111;
    seg_neg_p0   = {C3_neg, C2_neg, C1_neg, C0_neg};
    case (mode_p0)
      LM_DUAL: begin
        seg_start_p0 = 4'b0101;
        seg_neg_p0   = {C3_neg, C3_neg, C1_neg, C1_neg};
      end
      LM_QUAD: begin
        seg_start_p0 = 4'b0001;
        seg_neg_p0   = {4{C3_neg}};
      end
      default: ;
    endcase
    if (!sgn_p0) seg_neg_p0 = 4'b0000;
  end

  // The +1 enters at each lane's lowest segment; higher segments take the chain carry.
  always_comb begin
    logic             carry;
    logic             cin;
    logic [SEG_W:0]   seg_sum;
    neg_p0  = '0;
    carry   = 1'b0;
    cin     = 1'b0;
    seg_sum = '0;
    for (int s = 0; s < 4; s++) begin
      cin     = seg_start_p0[s] ? seg_neg_p0[s] : carry;
      seg_sum = {1'b0, prod_in[s*SEG_W +: SEG_W] ^ {SEG_W{seg_neg_p0[s]}}}
              + {{SEG_W{1'b0}}, cin};
      neg_p0[s*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
      carry   = seg_sum[SEG_W];
    end
  end

  always_comb begin
    ext_p0 = '0;
    case (mode_p0)
      LM_DUAL: begin
        for (int j = 0; j < 2; j++) begin
          ext_p0[j*2*ACC_W +: 2*ACC_W] =
            {{(2*ACC_W-2*SEG_W){sgn_p0 & neg_p0[j*2*SEG_W + 2*SEG_W-1]}},
             neg_p0[j*2*SEG_W +: 2*SEG_W]};
        end
      end
      LM_QUAD: begin
        ext_p0 = {{(A_W-P_W){sgn_p0 & neg_p0[P_W-1]}}, neg_p0};
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          ext_p0[i*ACC_W +: ACC_W] =
            {{(ACC_W-SEG_W){sgn_p0 & neg_p0[i*SEG_W + SEG_W-1]}},
             neg_p0[i*SEG_W +: SEG_W]};
        end
      end
    endcase
  end

  // ---------------- stage 1 register ----------------
  logic                   vld_p1;
  logic [A_W-1:0]         ext_p1;
  lane_mode_t             mode_p1;
  logic                   mac_p1;
  logic                   clr_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      ext_p1  <= ext_p0;
      mode_p1 <= mode_p0;
      mac_p1  <= cfg[2];
      clr_p1  <= acc_clr;
    end
  end

  // ---------------- stage 2: load or accumulate ----------------
  logic [A_W-1:0]         acc_p2;
  lane_mode_t             mode_p2;
  logic                   live_p2;
  logic                   vld_p2;
  logic                   load_p1;
  logic [A_W-1:0]         sum_p1;

  // After reset or a lane-mode change the held lanes mean nothing, so the beat loads.
  assign load_p1 = !mac_p1 || clr_p1 || (mode_p1 != mode_p2) || !live_p2;

  always_comb begin
    sum_p1 = acc_p2;
    case (mode_p1)
      LM_DUAL: begin
        for (int j = 0; j < 2; j++) begin
          sum_p1[j*2*ACC_W +: 2*ACC_W] =
            acc_p2[j*2*ACC_W +: 2*ACC_W] + ext_p1[j*2*ACC_W +: 2*ACC_W];
        end
      end
      LM_QUAD: begin
        sum_p1 = acc_p2 + ext_p1;
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          sum_p1[i*ACC_W +: ACC_W] = acc_p2[i*ACC_W +: ACC_W] + ext_p1[i*ACC_W +: ACC_W];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      acc_p2  <= '0;
      mode_p2 <= LM_SINGLE;
      live_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        acc_p2  <= load_p1 ? ext_p1 : sum_p1;
        mode_p2 <= mode_p1;
        live_p2 <= 1'b1;
      end
    end
  end

  assign acc_out   = acc_p2;
  assign out_valid = vld_p2;

`ifdef MAC_SIGN_RESTORE_OVF_EN
  // Carry-out of the MSB is recovered from the operand and result MSBs alone.
  function automatic logic add_ovf_bit(input logic a, input logic b, input logic r,
                                       input logic sgn);
    if (sgn) return (a == b) && (r != a);
    return (a & b) | ((a ^ b) & ~r);
  endfunction

  logic                   sgn_p1;
  logic [3:0]             add_ovf_p1;
  logic [3:0]             ovf_p2;

  always_ff @(posedge clk) begin
    if (en) sgn_p1 <= sgn_p0;
  end

  always_comb begin
    add_ovf_p1 = '0;
    for (int k = 0; k < 4; k++) begin
      add_ovf_p1[k] = lane_top_mask(mode_p1)[k] &
                      add_ovf_bit(acc_p2[(k+1)*ACC_W-1], ext_p1[(k+1)*ACC_W-1],
                                  sum_p1[(k+1)*ACC_W-1], sgn_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_p2 <= '0;
    end else if (en && vld_p1) begin
      ovf_p2 <= load_p1 ? 4'b0000 : (ovf_p2 | add_ovf_p1);
    end
  end

  assign ovf = ovf_p2;
`else
  assign ovf = 4'b0000;
`endif

endmodule

// File: tb/tb_mac_sign_restore_acc.sv
// Directed bench for mac_sign_restore_acc: hand-computed vectors for sign restore, lane isolation, MAC, stall and reset.
module tb_mac_sign_restore_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   cfg;
  logic         in_valid;
  logic         acc_clr;
  logic [63:0]  prod_in;
  logic         C0_neg, C1_neg, C2_neg, C3_neg;
  logic [127:0] acc_out;
  logic         out_valid;
  logic [3:0]   ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_sign_restore_acc dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg),
    .in_valid  (in_valid),
    .acc_clr   (acc_clr),
    .prod_in   (prod_in),
    .C0_neg    (C0_neg),
    .C1_neg    (C1_neg),
    .C2_neg    (C2_neg),
    .C3_neg    (C3_neg),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [3:0] c, input logic clr,
                     input logic [63:0] p, input logic [3:0] n);
    @(negedge clk);
    in_valid = v;
    cfg      = c;
    acc_clr  = clr;
    prod_in  = p;
    {C3_neg, C2_neg, C1_neg, C0_neg} = n;
  endtask

  task automatic idle();
    put(1'b0, cfg, 1'b0, 64'h0, 4'b0000);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; returns just after the edge that presents its result.
  task automatic run1(input logic [3:0] c, input logic clr, input logic [63:0] p,
                      input logic [3:0] n);
    put(1'b1, c, clr, p, n);
    idle();
    cyc();
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; cfg = 4'h0; in_valid = 1'b0; acc_clr = 1'b0;
    prod_in = 64'h0; {C3_neg, C2_neg, C1_neg, C0_neg} = 4'b0000;
    repeat (3) cyc();
    chk("rst_vld", {127'h0, out_valid}, 128'h0);
    chk("rst_acc", acc_out, 128'h0);
    chk("rst_ovf", {124'h0, ovf}, 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single MUL signed, with latency and one-cycle valid pulse
    put(1'b1, 4'b1000, 1'b0, {16'h7FFF, 16'h0000, 16'h0006, 16'h0006}, 4'b1101);
    cyc();
    chk("mul_lat0", {127'h0, out_valid}, 128'h0);
    idle();
    cyc();
    chk("mul_vld", {127'h0, out_valid}, 128'h1);
    chk("mul_single", acc_out, {32'hFFFF8001, 32'h00000000, 32'h00000006, 32'hFFFFFFFA});
    idle();
    cyc();
    chk("mul_pulse", {127'h0, out_valid}, 128'h0);
    chk("mul_hold", acc_out, {32'hFFFF8001, 32'h00000000, 32'h00000006, 32'hFFFFFFFA});

    // Dual: carry from lane 0 must not reach lane 1
    run1(4'b1001, 1'b0, {32'h00000001, 32'h00000000}, 4'b0010);
    chk("dual_iso", acc_out, {64'h1, 64'h0});
    // Dual: carry must ripple inside a lane; C0/C2 ignored
    run1(4'b1001, 1'b0, {32'h00010001, 32'h00000005}, 4'b1101);
    chk("dual_chain", acc_out, {64'hFFFFFFFF_FFFEFFFF, 64'h0000000000000005});

    // Quad negate: only C3 counts
    run1(4'b1010, 1'b0, 64'h1, 4'b1000);
    chk("quad_neg", acc_out, {128{1'b1}});

    // Unsigned: flags ignored, zero extension
    run1(4'b0000, 1'b0, {32'h0, 16'h8000, 16'hFFFF}, 4'b1111);
    chk("unsigned", acc_out, {64'h0, 32'h00008000, 32'h0000FFFF});

    // Single MAC: +5 (clr), -3, stall, -4, +1
    run1(4'b1100, 1'b1, 64'h5, 4'b0000);
    chk("mac_5", acc_out, 128'h5);
    run1(4'b1100, 1'b0, 64'h3, 4'b0001);
    chk("mac_2", acc_out, 128'h2);
    put(1'b1, 4'b1100, 1'b1, 64'h77, 4'b0000);
    en = 1'b0;
    cyc();
    cyc();
    chk("stall_vld", {127'h0, out_valid}, 128'h1);
    chk("stall_acc", acc_out, 128'h2);
    idle();
    en = 1'b1;
    cyc();
    chk("bubble_vld", {127'h0, out_valid}, 128'h0);
    chk("bubble_acc", acc_out, 128'h2);
    put(1'b1, 4'b1100, 1'b0, 64'h4, 4'b0001);
    cyc();
    @(negedge clk);
    en = 1'b0;
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("midstall_vld", {127'h0, out_valid}, 128'h0);
    chk("midstall_acc", acc_out, 128'h2);
    @(negedge clk);
    en = 1'b1;
    cyc();
    chk("mac_m2_vld", {127'h0, out_valid}, 128'h1);
    chk("mac_m2", acc_out, 128'hFFFFFFFE);
    run1(4'b1100, 1'b0, 64'h1, 4'b0000);
    chk("mac_m1", acc_out, 128'hFFFFFFFF);

    // Mode switch: quad MAC without clr loads, then adds
    run1(4'b1110, 1'b0, 64'h10, 4'b0000);
    chk("quad_load", acc_out, 128'h10);
    run1(4'b1110, 1'b0, 64'h20, 4'b0000);
    chk("quad_add", acc_out, 128'h30);
    run1(4'b1110, 1'b0, 64'h40, 4'b1000);
    chk("quad_sub", acc_out, {{124{1'b1}}, 4'h0});
    chk("quad_ovf", {124'h0, ovf}, 128'h0);

    // Reset with beats in flight
    put(1'b1, 4'b1100, 1'b1, 64'h9, 4'b0000);
    put(1'b1, 4'b1100, 1'b0, 64'h7, 4'b0000);
    cyc();
    chk("pre_rst_vld", {127'h0, out_valid}, 128'h1);
    chk("pre_rst_acc", acc_out, 128'h9);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("mid_rst_vld", {127'h0, out_valid}, 128'h0);
    chk("mid_rst_acc", acc_out, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("drop_vld", {127'h0, out_valid}, 128'h0);
    run1(4'b1100, 1'b0, 64'h3, 4'b0000);
    chk("post_rst_vld", {127'h0, out_valid}, 128'h1);
    chk("post_rst_acc", acc_out, 128'h3);

`ifdef MAC_SIGN_RESTORE_OVF_EN
    // 65538 * 0x7FFF = 0x7FFFFFFE still fits; the next add overflows
    for (int k = 0; k < 65538; k++) begin
      put(1'b1, 4'b1100, (k == 0), 64'h7FFF, 4'b0000);
    end
    idle();
    cyc();
    chk("ovf_pre_acc", acc_out, 128'h7FFFFFFE);
    chk("ovf_pre", {124'h0, ovf}, 128'h0);
    run1(4'b1100, 1'b0, 64'h7FFF, 4'b0000);
    chk("ovf_rise_acc", acc_out, 128'h80007FFD);
    chk("ovf_rise", {124'h0, ovf}, 128'h1);
    run1(4'b1100, 1'b0, 64'h1, 4'b0000);
    chk("ovf_sticky", {124'h0, ovf}, 128'h1);
    run1(4'b1100, 1'b1, 64'h1, 4'b0000);
    chk("ovf_clr", {124'h0, ovf}, 128'h0);
`else
    chk("ovf_tied", {124'h0, ovf}, 128'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
